// File: rtl/ksa8_pkg.sv
// ----------------------------------------------------------------------------
// ksa8_pkg
//
// Purpose:
//   Shared definitions for the KSA8 response checker and the benches that
//   drive it.
//
// Contents:
//   KSA_W        operand width of the Kogge-Stone adder (8)
//   RES_W        result width {cout,sum[7:0]} (9)
//   chk_state_t  checker control states
//   ksa_golden() reference result a + b + cin, RES_W bits wide
// ----------------------------------------------------------------------------
package ksa8_pkg;

  localparam int KSA_W = 8;
  localparam int RES_W = KSA_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_t;

  // Reference sum. Both operands are zero-extended so the carry-out lands in
  // the top bit, matching the adder's {cout,sum} bit ordering.
  function automatic logic [RES_W-1:0] ksa_golden(
    input logic [KSA_W-1:0] a,
    input logic [KSA_W-1:0] b,
    input logic             cin
  );
    return {1'b0, a} + {1'b0, b} + {{KSA_W{1'b0}}, cin};
  endfunction

endpackage : ksa8_pkg

// File: rtl/ksa8_result_checker_exp_pipe.sv
// ----------------------------------------------------------------------------
// exp_pipe
//
// Purpose:
//   LATENCY-deep shift register carrying a valid bit plus the 9-bit expected
//   result for each accepted operand vector. An entry pushed at edge k sits
//   in the last stage during the cycle after edge k+LATENCY-1, so it is
//   consumed at edge k+LATENCY.
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst_n       in   synchronous active-low reset, clears all stages
//   flush       in   synchronous clear of every valid bit
//   push_valid  in   write an entry into stage 0 this cycle
//   push_data   in   RES_W expected result for the pushed entry
//   out_valid   out  last stage holds a valid entry
//   out_data    out  expected result held in the last stage
//   any_valid   out  at least one stage holds a valid entry
//
// Parameters:
//   LATENCY     pipe depth, 1..16
// ----------------------------------------------------------------------------
module exp_pipe
  import ksa8_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push_valid,
  input  logic [RES_W-1:0] push_data,
  output logic             out_valid,
  output logic [RES_W-1:0] out_data,
  output logic             any_valid
);

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] vld_d;
  logic [RES_W-1:0]   dat_q [LATENCY];
  logic [RES_W-1:0]   dat_d [LATENCY];

  // The pipe advances every cycle with no stall, so a bubble is simply a
  // stage whose valid bit is low. Flush only clears valids; stale data in
  // an invalid stage is never looked at.
  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = push_valid;
    dat_d[0] = push_data;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
    if (flush) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_data  = dat_q[LATENCY-1];
  assign any_valid = |vld_q;

endmodule : exp_pipe

// File: rtl/ksa8_result_checker.sv
// ----------------------------------------------------------------------------
// ksa8_result_checker
//
// Purpose:
//   Response checker for the 8-bit Kogge-Stone adder. Every operand vector
//   accepted in RUN has its golden result pushed into a LATENCY-deep pipe;
//   when that entry reaches the end of the pipe it is compared with the
//   adder's bit-level outputs. Pass/fail counts saturate, and the first
//   mismatch since start is recorded.
//
// Ports:
//   clk, rst_n          clock (rising edge) and synchronous active-low reset
//   start               restart: flush pipe, clear counts/record, go to RUN
//   stop                stop accepting, drain the pipe, then DONE
//   in_valid, a, b, cin operand vector copy (honoured only in RUN)
//   sum0..sum7, cout    adder outputs, sampled when the pipe end is valid
//   busy                state is RUN or DRAIN
//   done                state is DONE
//   mismatch            one-cycle pulse per failed compare
//   pass_cnt, fail_cnt  saturating compare counters
//   first_fail_valid    a mismatch has been recorded since start
//   first_fail_exp/got  {cout,sum} expected/observed at the first mismatch
//
// Parameters:
//   LATENCY  adder pipeline depth in cycles, 1..16
//   CNT_W    counter width
// ----------------------------------------------------------------------------
module ksa8_result_checker
  import ksa8_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [KSA_W-1:0] a,
  input  logic [KSA_W-1:0] b,
  input  logic             cin,
  input  logic             sum0,
  input  logic             sum1,
  input  logic             sum2,
  input  logic             sum3,
  input  logic             sum4,
  input  logic             sum5,
  input  logic             sum6,
  input  logic             sum7,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_valid,
  output logic [RES_W-1:0] first_fail_exp,
  output logic [RES_W-1:0] first_fail_got
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  chk_state_t       state_q, state_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             mismatch_q, mismatch_d;
  logic             ff_valid_q, ff_valid_d;
  logic [RES_W-1:0] ff_exp_q, ff_exp_d;
  logic [RES_W-1:0] ff_got_q, ff_got_d;

  logic [RES_W-1:0] got;
  logic [RES_W-1:0] push_exp;
  logic [RES_W-1:0] pipe_exp;
  logic             pipe_out_valid;
  logic             pipe_any_valid;
  logic             accept;
  logic             compare;
  logic             match;

  // Pack the adder's loose bit ports into the same {cout,sum} layout that
  // the golden function produces.
  assign got = {cout, sum7, sum6, sum5, sum4, sum3, sum2, sum1, sum0};

  // A vector is taken only in RUN, and not in a cycle that also stops or
  // restarts the checker. A restart flushes the pipe, so pushing in that
  // same cycle would leave a stale entry behind.
  assign accept   = (state_q == ST_RUN) && in_valid && !stop && !start;
  assign push_exp = ksa_golden(a, b, cin);

  exp_pipe #(
    .LATENCY (LATENCY)
  ) u_exp_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (start),
    .push_valid (accept),
    .push_data  (push_exp),
    .out_valid  (pipe_out_valid),
    .out_data   (pipe_exp),
    .any_valid  (pipe_any_valid)
  );

  // The entry leaving the pipe during a restart belongs to the old run and
  // is dropped rather than counted.
  assign compare = pipe_out_valid && !start;
  assign match   = (pipe_exp == got);

  // Control FSM. Start takes priority over everything, including a stop in
  // the same cycle. DRAIN waits until no entry is left in flight, which
  // takes at most LATENCY cycles because nothing new is pushed.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_RUN:   if (stop) state_d = ST_DRAIN;
        ST_DRAIN: if (!pipe_any_valid) state_d = ST_DONE;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Compare bookkeeping: saturating counters, the one-cycle mismatch pulse
  // and a first-fail record that is written once and then held until the
  // next start.
  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    mismatch_d = 1'b0;
    ff_valid_d = ff_valid_q;
    ff_exp_d   = ff_exp_q;
    ff_got_d   = ff_got_q;
    if (start) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
      ff_valid_d = 1'b0;
      ff_exp_d   = '0;
      ff_got_d   = '0;
    end else if (compare) begin
      if (match) begin
        if (pass_cnt_q != CNT_MAX) begin
          pass_cnt_d = pass_cnt_q + CNT_ONE;
        end
      end else begin
        mismatch_d = 1'b1;
        if (fail_cnt_q != CNT_MAX) begin
          fail_cnt_d = fail_cnt_q + CNT_ONE;
        end
        if (!ff_valid_q) begin
          ff_valid_d = 1'b1;
          ff_exp_d   = pipe_exp;
          ff_got_d   = got;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      mismatch_q <= 1'b0;
      ff_valid_q <= 1'b0;
      ff_exp_q   <= '0;
      ff_got_q   <= '0;
    end else begin
      state_q    <= state_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      mismatch_q <= mismatch_d;
      ff_valid_q <= ff_valid_d;
      ff_exp_q   <= ff_exp_d;
      ff_got_q   <= ff_got_d;
    end
  end

  assign busy             = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done             = (state_q == ST_DONE);
  assign mismatch         = mismatch_q;
  assign pass_cnt         = pass_cnt_q;
  assign fail_cnt         = fail_cnt_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_exp   = ff_exp_q;
  assign first_fail_got   = ff_got_q;

endmodule : ksa8_result_checker

// File: tb/tb_ksa8_result_checker.sv
// ----------------------------------------------------------------------------
// tb_ksa8_result_checker
//
// Directed bench for the KSA8 response checker. A behavioural two-stage
// adder model feeds the checker's sum/cout ports; each vector can carry an
// XOR corruption mask to emulate a faulty adder. A second checker with
// 4-bit counters shares all inputs and is used for saturation.
// ----------------------------------------------------------------------------
module tb_ksa8_result_checker;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        cin;
  logic [8:0]  corrupt;
  logic        sum0, sum1, sum2, sum3, sum4, sum5, sum6, sum7, cout;

  logic        busy, done, mismatch, ffv;
  logic [15:0] pass_cnt, fail_cnt;
  logic [8:0]  ffe, ffg;

  logic        s_busy, s_done, s_mismatch, s_ffv;
  logic [3:0]  s_pass, s_fail;
  logic [8:0]  s_ffe, s_ffg;

  logic [8:0]  mdl_s0, mdl_s1;

  int n_checks = 0;
  int n_fail   = 0;
  int mm_count = 0;
  int mm_base  = 0;

  always #5 clk = ~clk;

  // Behavioural adder with LAT=2 register stages; the corruption mask
  // travels with its vector so a fault shows up exactly at its compare.
  always @(posedge clk) begin
    mdl_s0 <= ({1'b0, a} + {1'b0, b} + {8'd0, cin}) ^ corrupt;
    mdl_s1 <= mdl_s0;
  end

  assign {cout, sum7, sum6, sum5, sum4, sum3, sum2, sum1, sum0} = mdl_s1;

  // Count mismatch pulses away from the active edge.
  always @(negedge clk) begin
    if (mismatch) mm_count++;
  end

  ksa8_result_checker #(.LATENCY(LAT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin),
    .sum0(sum0), .sum1(sum1), .sum2(sum2), .sum3(sum3),
    .sum4(sum4), .sum5(sum5), .sum6(sum6), .sum7(sum7), .cout(cout),
    .busy(busy), .done(done), .mismatch(mismatch),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_valid(ffv), .first_fail_exp(ffe), .first_fail_got(ffg)
  );

  ksa8_result_checker #(.LATENCY(LAT), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin),
    .sum0(sum0), .sum1(sum1), .sum2(sum2), .sum3(sum3),
    .sum4(sum4), .sum5(sum5), .sum6(sum6), .sum7(sum7), .cout(cout),
    .busy(s_busy), .done(s_done), .mismatch(s_mismatch),
    .pass_cnt(s_pass), .fail_cnt(s_fail),
    .first_fail_valid(s_ffv), .first_fail_exp(s_ffe), .first_fail_got(s_ffg)
  );

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one operand vector for exactly one edge; in_valid stays high so
  // callers can stream back to back, and idle_inputs drops it.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input logic cv, input logic [8:0] mask);
    a        = av;
    b        = bv;
    cin      = cv;
    corrupt  = mask;
    in_valid = 1'b1;
    tick(1);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    corrupt  = 9'h000;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0; corrupt = 9'h000;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mismatch: got %b expected 0", mismatch); end
    n_checks++; if (pass_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_pass: got %0d expected 0", pass_cnt); end
    n_checks++; if (fail_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_fail: got %0d expected 0", fail_cnt); end
    n_checks++; if (ffv !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ffv: got %b expected 0", ffv); end
    n_checks++; if (ffe !== 9'h000) begin n_fail++; $display("[TB] FAIL reset_ffe: got %h expected 000", ffe); end
    n_checks++; if (ffg !== 9'h000) begin n_fail++; $display("[TB] FAIL reset_ffg: got %h expected 000", ffg); end
  endtask

  task automatic test_ignored_idle();
    applyStimulus(8'h12, 8'h34, 1'b0, 9'h000);
    applyStimulus(8'h56, 8'h78, 1'b1, 9'h001);
    applyStimulus(8'h9A, 8'hBC, 1'b0, 9'h000);
    idle_inputs();
    tick(4);
    n_checks++; if (pass_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL idle_pass: got %0d expected 0", pass_cnt); end
    n_checks++; if (fail_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL idle_fail: got %0d expected 0", fail_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_all_ones();
    pulse_start();
    mm_base = mm_count;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL ones_busy_run: got %b expected 1", busy); end
    applyStimulus(8'hFF, 8'hFF, 1'b1, 9'h000);
    idle_inputs();
    tick(1);
    n_checks++; if (pass_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL ones_pass_early: got %0d expected 0", pass_cnt); end
    tick(1);
    n_checks++; if (pass_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL ones_pass: got %0d expected 1", pass_cnt); end
    n_checks++; if (fail_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL ones_fail: got %0d expected 0", fail_cnt); end
    tick(2);
    n_checks++; if (mm_count - mm_base !== 0) begin n_fail++; $display("[TB] FAIL ones_mismatch_pulses: got %0d expected 0", mm_count - mm_base); end
    n_checks++; if (ffv !== 1'b0) begin n_fail++; $display("[TB] FAIL ones_ffv: got %b expected 0", ffv); end
    pulse_stop();
    tick(LAT);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL ones_done: got %b expected 1", done); end
  endtask

  task automatic test_streaming();
    pulse_start();
    mm_base = mm_count;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(i[7:0], 8'(255 - i), i[0], 9'h000);
    end
    idle_inputs();
    pulse_stop();
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_drain_state: got busy=%b done=%b expected busy=1 done=0", busy, done); end
    tick(LAT - 1);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_done_early: got %b expected 0", done); end
    tick(1);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_done: got %b expected 1", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_busy: got %b expected 0", busy); end
    n_checks++; if (pass_cnt !== 16'd256) begin n_fail++; $display("[TB] FAIL stream_pass: got %0d expected 256", pass_cnt); end
    n_checks++; if (fail_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL stream_fail: got %0d expected 0", fail_cnt); end
    n_checks++; if (mm_count - mm_base !== 0) begin n_fail++; $display("[TB] FAIL stream_mismatch_pulses: got %0d expected 0", mm_count - mm_base); end
  endtask

  task automatic test_fault();
    pulse_start();
    mm_base = mm_count;
    // sum3 stuck at 0: 0x08 + 0x00 should be 0x008, adder returns 0x000.
    applyStimulus(8'h08, 8'h00, 1'b0, 9'h008);
    idle_inputs();
    tick(1);
    n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("[TB] FAIL fault_mm_early: got %b expected 0", mismatch); end
    tick(1);
    n_checks++; if (mismatch !== 1'b1) begin n_fail++; $display("[TB] FAIL fault_mm_pulse: got %b expected 1", mismatch); end
    n_checks++; if (fail_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL fault_fail1: got %0d expected 1", fail_cnt); end
    n_checks++; if (pass_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL fault_pass: got %0d expected 0", pass_cnt); end
    n_checks++; if (ffv !== 1'b1) begin n_fail++; $display("[TB] FAIL fault_ffv: got %b expected 1", ffv); end
    n_checks++; if (ffe !== 9'h008) begin n_fail++; $display("[TB] FAIL fault_ffe: got %h expected 008", ffe); end
    n_checks++; if (ffg !== 9'h000) begin n_fail++; $display("[TB] FAIL fault_ffg: got %h expected 000", ffg); end
    tick(1);
    n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("[TB] FAIL fault_mm_one_cycle: got %b expected 0", mismatch); end
    // Second fault: expected 0x011, adder returns 0x010; record must hold.
    applyStimulus(8'h10, 8'h01, 1'b0, 9'h001);
    idle_inputs();
    tick(3);
    n_checks++; if (fail_cnt !== 16'd2) begin n_fail++; $display("[TB] FAIL fault_fail2: got %0d expected 2", fail_cnt); end
    n_checks++; if (mm_count - mm_base !== 2) begin n_fail++; $display("[TB] FAIL fault_mismatch_pulses: got %0d expected 2", mm_count - mm_base); end
    n_checks++; if (ffe !== 9'h008) begin n_fail++; $display("[TB] FAIL fault_ffe_held: got %h expected 008", ffe); end
    n_checks++; if (ffg !== 9'h000) begin n_fail++; $display("[TB] FAIL fault_ffg_held: got %h expected 000", ffg); end
  endtask

  task automatic test_stop_with_valid();
    pulse_start();
    applyStimulus(8'h01, 8'h02, 1'b0, 9'h000);
    a = 8'h03; b = 8'h04; cin = 1'b0; in_valid = 1'b1; stop = 1'b1;
    tick(1);
    stop = 1'b0;
    idle_inputs();
    tick(LAT + 1);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL stopv_done: got %b expected 1", done); end
    n_checks++; if (pass_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL stopv_pass: got %0d expected 1", pass_cnt); end
    applyStimulus(8'h20, 8'h20, 1'b0, 9'h000);
    applyStimulus(8'h21, 8'h21, 1'b1, 9'h004);
    idle_inputs();
    tick(4);
    n_checks++; if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL done_ignore: got pass=%0d fail=%0d expected pass=1 fail=0", pass_cnt, fail_cnt); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL done_hold: got %b expected 1", done); end
  endtask

  task automatic test_restart();
    pulse_start();
    mm_base = mm_count;
    applyStimulus(8'h05, 8'h05, 1'b0, 9'h001);
    applyStimulus(8'h06, 8'h06, 1'b0, 9'h000);
    idle_inputs();
    pulse_start();
    n_checks++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL restart_cnt: got pass=%0d fail=%0d expected 0/0", pass_cnt, fail_cnt); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL restart_busy: got %b expected 1", busy); end
    tick(4);
    n_checks++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL restart_flushed: got pass=%0d fail=%0d expected 0/0", pass_cnt, fail_cnt); end
    n_checks++; if (ffv !== 1'b0) begin n_fail++; $display("[TB] FAIL restart_ffv: got %b expected 0", ffv); end
    n_checks++; if (mm_count - mm_base !== 0) begin n_fail++; $display("[TB] FAIL restart_mismatch_pulses: got %0d expected 0", mm_count - mm_base); end
  endtask

  task automatic test_midrun_reset();
    pulse_start();
    applyStimulus(8'h08, 8'h00, 1'b0, 9'h008);
    idle_inputs();
    tick(2);
    n_checks++; if (fail_cnt !== 16'd1 || ffv !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_pre: got fail=%0d ffv=%b expected 1/1", fail_cnt, ffv); end
    applyStimulus(8'h01, 8'h01, 1'b0, 9'h000);
    idle_inputs();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_done: got %b expected 0", done); end
    n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mismatch: got %b expected 0", mismatch); end
    n_checks++; if (fail_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL rst_fail: got %0d expected 0", fail_cnt); end
    n_checks++; if (ffv !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ffv: got %b expected 0", ffv); end
    n_checks++; if (ffe !== 9'h000 || ffg !== 9'h000) begin n_fail++; $display("[TB] FAIL rst_ff_fields: got exp=%h got=%h expected 000/000", ffe, ffg); end
    tick(3);
    n_checks++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL rst_aborted: got pass=%0d fail=%0d expected 0/0", pass_cnt, fail_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_saturation();
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i[7:0], 8'h01, 1'b0, 9'h001);
    end
    idle_inputs();
    pulse_stop();
    tick(LAT + 2);
    n_checks++; if (s_fail !== 4'd15) begin n_fail++; $display("[TB] FAIL sat_fail: got %0d expected 15", s_fail); end
    n_checks++; if (s_pass !== 4'd0) begin n_fail++; $display("[TB] FAIL sat_pass: got %0d expected 0", s_pass); end
    n_checks++; if (s_done !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_done: got %b expected 1", s_done); end
    n_checks++; if (s_ffe !== 9'h001 || s_ffg !== 9'h000) begin n_fail++; $display("[TB] FAIL sat_ff_fields: got exp=%h got=%h expected 001/000", s_ffe, s_ffg); end
    n_checks++; if (fail_cnt !== 16'd20) begin n_fail++; $display("[TB] FAIL wide_fail: got %0d expected 20", fail_cnt); end
    tick(3);
    n_checks++; if (s_fail !== 4'd15) begin n_fail++; $display("[TB] FAIL sat_hold: got %0d expected 15", s_fail); end
  endtask

  // Safety net: the sequence is fixed-length, so this only fires on a hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_ignored_idle();
    test_all_ones();
    test_streaming();
    test_fault();
    test_stop_with_valid();
    test_restart();
    test_midrun_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ksa8_result_checker

// File: doc/ksa8_result_checker.md
# ksa8_result_checker

Synthesizable response checker for the 8-bit Kogge-Stone adder (KSA8), the consuming end of its bit-level operand/sum interface. It takes a copy of every operand vector sent to the adder, delays the golden result `a+b+cin` by the adder's pipeline depth, and samples the adder's `sum0..sum7`/`cout` ports. It compares the two, keeps pass/fail counters and records the first mismatch. It sits beside the adder in bench and on-chip self-test builds.

## Interface
- `LATENCY`, default 2: clk cycles from operand acceptance to a valid adder output; range 1..16.
- `CNT_W`, default 16: width of the pass/fail counters.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
- `start`  in  1  pulse; clears counters and first-fail record, flushes the pipe, enters RUN.
- `stop`  in  1  pulse; ends acceptance, drains the pipe, then DONE.
- `in_valid`  in  1  operand vector valid this cycle.
- `a`, `b`  in  8 each  operand copy, bit i matches adder port `ai`/`bi`.
- `cin`  in  1  carry-in copy.
- `sum0`..`sum7`, `cout`  in  1 each  adder outputs, bit-level as on KSA8.
- `busy`  out  1  state is RUN or DRAIN.
- `done`  out  1  state is DONE.
- `mismatch`  out  1  one-cycle pulse per failed compare.
- `pass_cnt`, `fail_cnt`  out  CNT_W each  saturating counts.
- `first_fail_valid`  out  1  a mismatch has been recorded since start.
- `first_fail_exp`, `first_fail_got`  out  9 each  `{cout,sum[7:0]}` expected/observed at the first mismatch.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on `start`.
- RUN -> DRAIN on `stop`.
- DRAIN -> DONE once the expected pipe holds no valid entries. Drain lasts LATENCY cycles at most.
- DONE -> RUN on `start`.
- `start` in any state restarts: pipe valids cleared, counters and first-fail record cleared, state RUN. `start` wins over `stop` when both occur in the same cycle.
- Acceptance: `in_valid` is honoured only in RUN. It is ignored in IDLE, DRAIN and DONE, and in the cycle `stop` is seen.
- Golden value: `exp = {1'b0,a} + {1'b0,b} + cin`, 9 bits, computed at acceptance and pushed into a LATENCY-deep valid+data shift pipe.
- Compare: when the pipe's last stage is valid, compare `exp` against `got = {cout,sum7..sum0}`.
  - Equal: `pass_cnt`+1.
  - Not equal: `fail_cnt`+1 and `mismatch` pulses. If `first_fail_valid`=0, latch exp/got and set it.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Only the first mismatch is recorded; later mismatches do not overwrite it.

## Timing
- Operand accepted at edge k. The adder output is sampled at edge k+LATENCY. Counters, `mismatch` and the first-fail fields update at that edge and are visible in the following cycle.
- Back-to-back `in_valid` every cycle is supported. Throughput is 1 compare/cycle.
- `stop` at edge k: operands in flight still complete. DONE is entered at the first edge where the pipe is empty, which is at most edge k+LATENCY. `done` is high from then on.
- Reset values: state IDLE, pipe valids 0, `busy`=0, `done`=0, `mismatch`=0, both counters 0, `first_fail_valid`=0, `first_fail_exp`=0, `first_fail_got`=0.
- `rst_n` low mid-RUN aborts in-flight compares. Nothing is counted for them.

## Structure
- Shared package `ksa8_pkg`:
  - state enum `chk_state_t`
  - constant `KSA_W=8`
  - function `ksa_golden(a,b,cin)` returning 9 bits, reused by generated benches.
- One sub-module, `exp_pipe`: parameterized LATENCY-deep valid+9-bit shift register with synchronous flush.
- Top level holds the FSM, bit-port packing, compare, counters and first-fail capture.

## Test plan
- All-ones: `a`=0xFF, `b`=0xFF, `cin`=1 against a correct model -> got=0x1FF, `pass_cnt`=1, `fail_cnt`=0, `mismatch` never high.
- Streaming: 256 back-to-back vectors `a`=i, `b`=255-i, `cin`=i[0] -> `pass_cnt`=256, then DONE exactly LATENCY cycles after `stop`.
- Injected fault: force `sum3`=0 with `a`=0x08, `b`=0x00, `cin`=0 -> `mismatch` pulses at k+LATENCY, `first_fail_exp`=0x008, `first_fail_got`=0x000. A second fault leaves the record unchanged.
- Ignored input: `in_valid` in IDLE and in DONE -> counters stay 0. `stop` and `in_valid` in the same cycle -> that vector is not counted.
- Restart/reset: `start` mid-RUN with 2 vectors in flight -> counters 0, no compare for the flushed vectors. `rst_n`=0 for one cycle -> all outputs at their reset values.
- Saturation with CNT_W=4: 20 failing vectors -> `fail_cnt`=15, held.
